// File: rtl/net_pkg.sv
// Shared network-path definitions: TX requester indices, TX arbiter states and
// the RX splitter's ethertype/protocol constants.
package net_pkg;

  localparam int unsigned ARP_IDX  = 0;
  localparam int unsigned ICMP_IDX = 1;
  localparam int unsigned UDP_IDX  = 2;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // One-hot grant to requester index
  function automatic logic [1:0] gnt_to_idx(input logic [2:0] gnt);
    return gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
  endfunction

  // Round-robin successor of a requester index, wrapping 2 -> 0
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : 2'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr.sv
// rr_arbiter3: combinational 3-way round-robin pick, first request at or after
// the pointer; a pointer of 3 behaves as 0.
module rr_arbiter3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt
);

  always_comb begin
    o_gnt = 3'b000;
    case (i_ptr)
      2'd1: begin
        if      (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
      end
      2'd2: begin
        if      (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
      end
      default: begin
        if      (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-atomic round-robin merge of ARP/ICMP/UDP TX streams onto one net stream,
// with a programmable inter-frame gap. Define TX_ARP_PRIORITY_EN for strict ARP priority.
module tx_frame_arbiter
  import net_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned GNT_W      = 3
) (
  input  logic             logic_clk,
  input  logic             logic_rst,
  input  logic [7:0]       arp_tdata_in,
  input  logic             arp_tvalid_in,
  output logic             arp_tready_out,
  input  logic             arp_tlast_in,
  input  logic [7:0]       icmp_tdata_in,
  input  logic             icmp_tvalid_in,
  output logic             icmp_tready_out,
  input  logic             icmp_tlast_in,
  input  logic [7:0]       udp_tdata_in,
  input  logic             udp_tvalid_in,
  output logic             udp_tready_out,
  input  logic             udp_tlast_in,
  output logic [7:0]       net_tdata_out,
  output logic             net_tvalid_out,
  input  logic             net_tready_in,
  output logic             net_tlast_out,
  output logic [GNT_W-1:0] grant_out,
  output logic             busy_out
);

  localparam int unsigned     CNT_W    = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IFG_CYCLES - 1);

  arb_state_e       r_state, w_state_nxt;
  logic [GNT_W-1:0] r_grant, w_grant_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [2:0]       w_req, w_rr_req, w_rr_gnt, w_pick;
  logic             w_ptr_adv;
  logic             w_beat;

  assign w_req = {udp_tvalid_in, icmp_tvalid_in, arp_tvalid_in};

`ifdef TX_ARP_PRIORITY_EN
  // ARP pre-empts the decision; ICMP/UDP share the pointer, which ARP never moves
  assign w_rr_req  = {w_req[UDP_IDX], w_req[ICMP_IDX], 1'b0};
  assign w_pick    = w_req[ARP_IDX] ? 3'b001 : w_rr_gnt;
  assign w_ptr_adv = ~r_grant[ARP_IDX];
`else
  assign w_rr_req  = w_req;
  assign w_pick    = w_rr_gnt;
  assign w_ptr_adv = 1'b1;
`endif

  rr_arbiter3 u_rr (
    .i_req (w_rr_req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  assign grant_out = r_grant;
  assign busy_out  = (r_state != IDLE);

  // Next-state and zero-latency pass-through of the granted source
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_beat          = 1'b0;
    net_tdata_out   = 8'h00;
    net_tvalid_out  = 1'b0;
    net_tlast_out   = 1'b0;
    arp_tready_out  = 1'b0;
    icmp_tready_out = 1'b0;
    udp_tready_out  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_grant_nxt = GNT_W'(w_pick);
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (r_grant[ARP_IDX]) begin
          net_tdata_out  = arp_tdata_in;
          net_tvalid_out = arp_tvalid_in;
          net_tlast_out  = arp_tlast_in;
          arp_tready_out = net_tready_in;
        end else if (r_grant[ICMP_IDX]) begin
          net_tdata_out   = icmp_tdata_in;
          net_tvalid_out  = icmp_tvalid_in;
          net_tlast_out   = icmp_tlast_in;
          icmp_tready_out = net_tready_in;
        end else if (r_grant[UDP_IDX]) begin
          net_tdata_out  = udp_tdata_in;
          net_tvalid_out = udp_tvalid_in;
          net_tlast_out  = udp_tlast_in;
          udp_tready_out = net_tready_in;
        end
        w_beat = net_tvalid_out & net_tready_in;
        if (w_beat && net_tlast_out) begin
          w_grant_nxt   = '0;
          w_gap_cnt_nxt = '0;
          if (w_ptr_adv) w_ptr_nxt = next_ptr(gnt_to_idx(r_grant[2:0]));
          w_state_nxt   = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == CNT_LAST) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= 2'd0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed scoreboard bench for tx_frame_arbiter: IFG_CYCLES=12 instance (a) and
// IFG_CYCLES=0 instance (b) share inputs; sources follow the selected instance.
module tb_tx_frame_arbiter;

  typedef struct {
    logic [2:0] gnt;
    logic       last;
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic       logic_clk;
  logic       logic_rst;
  logic [7:0] s_data  [3];
  logic       s_valid [3];
  logic       s_last  [3];
  logic       net_tready;
  bit         sel;
  bit         tog;

  logic [7:0] a_data, b_data, m_data;
  logic       a_valid, b_valid, m_valid;
  logic       a_last, b_last, m_last;
  logic       a_busy, b_busy, m_busy;
  logic [2:0] a_grant, b_grant, m_grant;
  logic [2:0] a_rdy, b_rdy, m_rdy;

  logic [8:0] sq [3][$];
  exp_t       exp_q[$];
  bit         acc [3];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  int         beats = 0;
  bit         in_frame = 0;
  bit         stall = 0;
  logic [7:0] stall_data;

  tx_frame_arbiter #(.IFG_CYCLES(12)) dut_a (
    .logic_clk(logic_clk), .logic_rst(logic_rst),
    .arp_tdata_in(s_data[0]), .arp_tvalid_in(s_valid[0]), .arp_tready_out(a_rdy[0]), .arp_tlast_in(s_last[0]),
    .icmp_tdata_in(s_data[1]), .icmp_tvalid_in(s_valid[1]), .icmp_tready_out(a_rdy[1]), .icmp_tlast_in(s_last[1]),
    .udp_tdata_in(s_data[2]), .udp_tvalid_in(s_valid[2]), .udp_tready_out(a_rdy[2]), .udp_tlast_in(s_last[2]),
    .net_tdata_out(a_data), .net_tvalid_out(a_valid), .net_tready_in(net_tready), .net_tlast_out(a_last),
    .grant_out(a_grant), .busy_out(a_busy)
  );

  tx_frame_arbiter #(.IFG_CYCLES(0)) dut_b (
    .logic_clk(logic_clk), .logic_rst(logic_rst),
    .arp_tdata_in(s_data[0]), .arp_tvalid_in(s_valid[0]), .arp_tready_out(b_rdy[0]), .arp_tlast_in(s_last[0]),
    .icmp_tdata_in(s_data[1]), .icmp_tvalid_in(s_valid[1]), .icmp_tready_out(b_rdy[1]), .icmp_tlast_in(s_last[1]),
    .udp_tdata_in(s_data[2]), .udp_tvalid_in(s_valid[2]), .udp_tready_out(b_rdy[2]), .udp_tlast_in(s_last[2]),
    .net_tdata_out(b_data), .net_tvalid_out(b_valid), .net_tready_in(net_tready), .net_tlast_out(b_last),
    .grant_out(b_grant), .busy_out(b_busy)
  );

  assign m_data  = sel ? b_data  : a_data;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_last  = sel ? b_last  : a_last;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_grant = sel ? b_grant : a_grant;
  assign m_rdy   = sel ? b_rdy   : a_rdy;

  initial begin
    logic_clk = 1'b0;
    forever #5 logic_clk = ~logic_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic src_frame(input int s, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) sq[s].push_back({(i == n - 1), 8'(first + i)});
  endtask

  task automatic exp_frame(input int s, input logic [7:0] first, input int n, input int gap);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.gnt  = 3'(1 << s);
      e.last = (i == n - 1);
      e.data = 8'(first + i);
      e.gap  = (i == 0) ? gap : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge logic_clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Handshake capture: a beat seen at the negedge completes on the next posedge
  initial begin
    forever begin
      @(negedge logic_clk);
      for (int s = 0; s < 3; s++) acc[s] = s_valid[s] && m_rdy[s];
    end
  end

  // Source models and downstream ready pattern, updated just after each posedge
  initial begin
    logic [8:0] tmp;
    forever begin
      @(posedge logic_clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        if (acc[s] && sq[s].size() > 0) tmp = sq[s].pop_front();
        acc[s] = 1'b0;
        if (sq[s].size() > 0) begin
          s_valid[s] = 1'b1;
          {s_last[s], s_data[s]} = sq[s][0];
        end else begin
          s_valid[s] = 1'b0;
          s_last[s]  = 1'b0;
          s_data[s]  = 8'h00;
        end
      end
      net_tready = tog ? ~net_tready : 1'b1;
    end
  end

  // Output monitor: scoreboard compare, stall stability, gap spacing
  initial begin
    exp_t e;
    forever begin
      @(negedge logic_clk);
      cyc++;
      if (logic_rst) begin
        in_frame = 1'b0;
        stall    = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'(m_data), 32'(stall_data));
        end
        if (m_grant == 3'b010) check("icmp_rdy", 32'(m_rdy[1]), 32'(net_tready));
        stall      = m_valid && !net_tready;
        stall_data = m_data;
        if (m_valid && net_tready) begin
          beats++;
          if (exp_q.size() == 0) begin
            check("extra_beat", 32'(m_data), 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("beat_grant", 32'(m_grant), 32'(e.gnt));
            check("beat_data", 32'(m_data), 32'(e.data));
            check("beat_last", 32'(m_last), 32'(e.last));
            if (!in_frame && e.gap != 0) check("frame_gap", 32'(cyc - last_cyc), 32'(e.gap));
            in_frame = !m_last;
            if (m_last) last_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    int b0;
    int n;
    logic_rst  = 1'b1;
    sel        = 1'b0;
    tog        = 1'b0;
    net_tready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      s_data[s]  = 8'h00;
      s_valid[s] = 1'b0;
      s_last[s]  = 1'b0;
    end

    // Reset values on both instances
    repeat (3) @(negedge logic_clk);
    check("rst_grant_a", 32'(a_grant), 32'd0);
    check("rst_busy_a", 32'(a_busy), 32'd0);
    check("rst_valid_a", 32'(a_valid), 32'd0);
    check("rst_last_a", 32'(a_last), 32'd0);
    check("rst_data_a", 32'(a_data), 32'd0);
    check("rst_rdy_a", 32'(a_rdy), 32'd0);
    check("rst_grant_b", 32'(b_grant), 32'd0);
    check("rst_busy_b", 32'(b_busy), 32'd0);
    logic_rst = 1'b0;

    // Single UDP frame, then an ARP byte requested during the gap
    @(negedge logic_clk);
    src_frame(2, 8'h11, 5);
    exp_frame(2, 8'h11, 5, 0);
    @(negedge logic_clk);
    check("arb_cycle_grant", 32'(m_grant), 32'd0);
    check("arb_cycle_valid", 32'(m_valid), 32'd0);
    @(negedge logic_clk);
    check("udp_grant", 32'(m_grant), 32'b100);
    check("udp_busy", 32'(m_busy), 32'd1);
    wait_drained("drain_udp", 50);
    src_frame(0, 8'hA5, 1);
    exp_frame(0, 8'hA5, 1, 14);
    for (int i = 1; i <= 12; i++) begin
      @(negedge logic_clk);
      check("gap_busy", 32'(m_busy), 32'd1);
      check("gap_grant", 32'(m_grant), 32'd0);
      check("gap_valid", 32'(m_valid | m_rdy[0]), 32'd0);
    end
    @(negedge logic_clk);
    check("idle_busy", 32'(m_busy), 32'd0);
    check("idle_grant", 32'(m_grant), 32'd0);
    @(negedge logic_clk);
    check("arp_after_gap", 32'(m_grant), 32'b001);
    wait_drained("drain_arp1", 20);

    // Simultaneous requests right after reset: ARP, ICMP, UDP
    @(negedge logic_clk);
    logic_rst = 1'b1;
    @(negedge logic_clk);
    logic_rst = 1'b0;
    src_frame(0, 8'hA0, 3);
    src_frame(1, 8'hC0, 2);
    src_frame(2, 8'hD0, 2);
    exp_frame(0, 8'hA0, 3, 0);
    exp_frame(1, 8'hC0, 2, 14);
    exp_frame(2, 8'hD0, 2, 14);
    wait_drained("drain_rr3", 200);

    // Backpressure on a 4-byte ICMP frame
    tog = 1'b1;
    b0  = beats;
    src_frame(1, 8'h31, 4);
    exp_frame(1, 8'h31, 4, 0);
    wait_drained("drain_bp", 100);
    check("bp_beats", 32'(beats - b0), 32'd4);
    tog = 1'b0;

    // Reset after byte 3 of a 6-byte UDP frame
    src_frame(2, 8'h61, 6);
    exp_frame(2, 8'h61, 3, 0);
    exp_q[exp_q.size() - 1].last = 1'b0;
    wait_drained("drain_part", 100);
    #2;
    logic_rst = 1'b1;
    #1;
    check("abort_grant", 32'(a_grant), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_valid", 32'(a_valid), 32'd0);
    check("abort_last", 32'(a_last), 32'd0);
    check("abort_data", 32'(a_data), 32'd0);
    check("abort_rdy", 32'(a_rdy), 32'd0);
    sq[2].delete();
    @(negedge logic_clk);
    @(negedge logic_clk);
    logic_rst = 1'b0;
    src_frame(0, 8'hB0, 2);
    src_frame(2, 8'h61, 6);
    exp_frame(0, 8'hB0, 2, 0);
    exp_frame(2, 8'h61, 6, 14);
    wait_drained("drain_resend", 150);

    // Zero-gap instance: back-to-back UDP frames with ARP arriving mid-frame
    @(negedge logic_clk);
    logic_rst = 1'b1;
    sel       = 1'b1;
    @(negedge logic_clk);
    @(negedge logic_clk);
    logic_rst = 1'b0;
    src_frame(2, 8'h71, 2);
    src_frame(2, 8'h73, 2);
    exp_frame(2, 8'h71, 2, 0);
    exp_frame(0, 8'h81, 1, 2);
    exp_frame(2, 8'h73, 2, 2);
    n = 0;
    do begin
      @(negedge logic_clk);
      n++;
    end while (m_grant != 3'b100 && n < 10);
    check("ifg0_udp_grant", 32'(m_grant), 32'b100);
    src_frame(0, 8'h81, 1);
    n = 0;
    do begin
      @(negedge logic_clk);
      n++;
    end while (!(m_valid && m_last && net_tready) && n < 10);
    check("ifg0_udp_last", 32'(m_last), 32'd1);
    @(negedge logic_clk);
    check("ifg0_idle_busy", 32'(m_busy), 32'd0);
    check("ifg0_idle_grant", 32'(m_grant), 32'd0);
    @(negedge logic_clk);
    check("ifg0_arp_grant", 32'(m_grant), 32'b001);
    check("ifg0_arp_busy", 32'(m_busy), 32'd1);
    wait_drained("drain_ifg0", 30);

    // Continuous ICMP/UDP with two ARP frames competing
    @(negedge logic_clk);
    logic_rst = 1'b1;
    @(negedge logic_clk);
    logic_rst = 1'b0;
    src_frame(0, 8'h91, 1);
    src_frame(0, 8'h92, 1);
    for (int i = 0; i < 3; i++) begin
      src_frame(1, 8'(8'hE1 + i), 1);
      src_frame(2, 8'(8'hF1 + i), 1);
    end
`ifdef TX_ARP_PRIORITY_EN
    exp_frame(0, 8'h91, 1, 0);
    exp_frame(0, 8'h92, 1, 2);
    exp_frame(1, 8'hE1, 1, 2);
    exp_frame(2, 8'hF1, 1, 2);
`else
    exp_frame(0, 8'h91, 1, 0);
    exp_frame(1, 8'hE1, 1, 2);
    exp_frame(2, 8'hF1, 1, 2);
    exp_frame(0, 8'h92, 1, 2);
`endif
    exp_frame(1, 8'hE2, 1, 2);
    exp_frame(2, 8'hF2, 1, 2);
    exp_frame(1, 8'hE3, 1, 2);
    exp_frame(2, 8'hF3, 1, 2);
    wait_drained("drain_mix", 100);

    repeat (3) @(negedge logic_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
